// File: rtl/io_ccff_pkg.sv
// Shared types and sizing helpers for the IO-column ccff configuration loader.
package io_ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int CCFF_CHAIN_LEN_DEF = 20;
  localparam int CCFF_WORD_W_DEF    = 8;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int CCFF_BIT_CNT_W_DEF  = cnt_width(CCFF_CHAIN_LEN_DEF + 1);
  localparam int CCFF_WBIT_CNT_W_DEF = cnt_width(CCFF_WORD_W_DEF);

endpackage

// File: rtl/io_ccff_serializer.sv
// Word-wide shift register feeding the chain LSB-first, with a per-word bit counter.
module io_ccff_serializer
  import io_ccff_pkg::*;
#(
  parameter int WORD_W = CCFF_WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              bit_o,
  output logic              last_o
);

  localparam int WB_W = cnt_width(WORD_W);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WB_W-1:0]   wbit_cnt_q, wbit_cnt_d;

  assign last_o = (wbit_cnt_q == WB_W'(WORD_W - 1));
  assign bit_o  = sreg_q[0];

  always_comb begin
    sreg_d     = sreg_q;
    wbit_cnt_d = wbit_cnt_q;
    if (load_i) begin
      sreg_d     = data_i;
      wbit_cnt_d = '0;
    end else if (shift_i) begin
      sreg_d = sreg_q >> 1;
      // Saturate on the last bit; the next load clears it.
      if (!last_o) wbit_cnt_d = wbit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      sreg_q     <= '0;
      wbit_cnt_q <= '0;
    end else begin
      sreg_q     <= sreg_d;
      wbit_cnt_q <= wbit_cnt_d;
    end
  end

endmodule

// File: rtl/io_ccff_loader.sv
// Loads an IO-tile ccff chain from host words; optional readback check under CCFF_CHECK_EN.
module io_ccff_loader
  import io_ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
  parameter int WORD_W    = CCFF_WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BIT_CNT_W = cnt_width(CHAIN_LEN + 1);

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 ser_bit, ser_last;

  io_ccff_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .load_i      (cfg_ready & cfg_valid),
    .shift_i     (ccff_shift_en),
    .data_i      (cfg_data),
    .bit_o       (ser_bit),
    .last_o      (ser_last)
  );

  assign busy      = (state_q != IDLE);
  assign ccff_head = ccff_shift_en & ser_bit;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    cfg_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: if (cfg_start) begin
        state_d   = LOAD;
        bit_cnt_d = '0;
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = SHIFT;
      end
      SHIFT: begin
        ccff_shift_en = 1'b1;
        bit_cnt_d     = bit_cnt_q + 1'b1;
        // Chain length wins over word position, so surplus bits of the last word are dropped.
        if (bit_cnt_q == BIT_CNT_W'(CHAIN_LEN - 1)) state_d = DONE;
        else if (ser_last)                          state_d = LOAD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cfg_abort) state_d = IDLE;
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef CCFF_CHECK_EN
  logic [CHAIN_LEN-1:0] shadow_q;
  logic [CHAIN_LEN-1:0] shadow_we;
  logic                 shadow_valid_q, err_q;
  logic                 start_accept;

  assign start_accept = (state_q == IDLE) && cfg_start && !cfg_abort;
  assign err          = err_q;

  for (genvar gi = 0; gi < CHAIN_LEN; gi++) begin : g_shadow_we
    assign shadow_we[gi] = ccff_shift_en && (bit_cnt_q == BIT_CNT_W'(gi));
  end

  // Shadow holds data only; validity is tracked separately, so no reset needed.
  always_ff @(posedge prog_clk) begin
    for (int i = 0; i < CHAIN_LEN; i++) begin
      if (shadow_we[i]) shadow_q[i] <= ccff_head;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      shadow_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      if (cfg_abort)              shadow_valid_q <= 1'b0;
      else if (state_q == DONE)   shadow_valid_q <= 1'b1;
      if (start_accept)           err_q <= 1'b0;
      else if (ccff_shift_en && shadow_valid_q && (ccff_tail != shadow_q[bit_cnt_q]))
        err_q <= 1'b1;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_io_ccff_loader.sv
// Directed bench for io_ccff_loader with a 20-flop chain model on head/tail.
module tb_io_ccff_loader;

  logic       prog_clk;
  logic       prog_reset_n;
  logic       cfg_start, cfg_abort, cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic       busy, done, err;

  io_ccff_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Chain model: bits enter at the top and leave from bit 0 after 20 shifts.
  logic [19:0] chain = '0;
  assign ccff_tail = chain[0];
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {ccff_head, chain[19:1]};

  logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'h0F};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          shift_cnt, done_cnt, err_first;
  logic [31:0] stream;
  logic        err_at_done;

  always @(negedge prog_clk) begin
    if (ccff_shift_en && err && err_first < 0) err_first = shift_cnt;
    if (ccff_shift_en) begin
      if (shift_cnt < 32) stream[shift_cnt] = ccff_head;
      shift_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge prog_clk);
      #1;
    end
  endtask

  // Runs one load from the start cycle (index 0) until done or abort, bounded to 300 cycles.
  task automatic do_load(input int stall_word, input int stall_cyc, input int abort_shift,
                         input bit extra_starts, output int done_cyc, output int stall_ok,
                         output bit aborted);
    int w, stall, cyc;
    bit acc, fin;
    w = 0; stall = 0; cyc = 0; fin = 0;
    done_cyc = -1; stall_ok = 0; aborted = 0; err_at_done = 1'bx;
    shift_cnt = 0; stream = '0; done_cnt = 0; err_first = -1;
    while (!fin && cyc < 300) begin
      cfg_start = (cyc == 0) || (extra_starts && (cyc == 12 || done));
      cfg_abort = (abort_shift >= 0) && ccff_shift_en && (shift_cnt == abort_shift);
      cfg_valid = (w < 3) && !(w == stall_word && stall < stall_cyc);
      cfg_data  = (w < 3) ? words[w] : 8'h00;
      if (w == stall_word && stall < stall_cyc && cfg_ready) begin
        if (!ccff_shift_en) stall_ok++;
        stall++;
      end
      if (done && done_cyc < 0) begin
        done_cyc    = cyc;
        err_at_done = err;
      end
      acc = cfg_valid && cfg_ready;
      if (cfg_abort) aborted = 1'b1;
      tick(1);
      if (acc) w++;
      if (done_cyc >= 0 || aborted) fin = 1'b1;
      cyc++;
    end
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
  endtask

  int dc, so;
  bit ab;

  initial begin
    prog_reset_n = 1'b0;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    tick(3);
    check("reset_outs", {26'd0, busy, done, err, cfg_ready, ccff_head, ccff_shift_en}, 32'd0);
    prog_reset_n = 1'b1;
    tick(2);

    // 1: basic load, A5/3C/0F -> F3CA5 LSB-first, done in cycle 24 of the load
    do_load(-1, 0, -1, 1'b0, dc, so, ab);
    tick(3);
    check("t1_stream", stream, 32'h000F_3CA5);
    check("t1_shifts", shift_cnt, 20);
    check("t1_done_cyc", dc, 24);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_err_at_done", {31'd0, err_at_done}, 0);
    check("t1_idle_busy", {31'd0, busy}, 0);
    $display("[TB] t1 basic load: done_cyc=%0d shifts=%0d stream=%h", dc, shift_cnt, stream);

    // 2: withhold valid for 5 LOAD cycles before the second word
    do_load(1, 5, -1, 1'b0, dc, so, ab);
    tick(3);
    check("t2_stall_cycles", so, 5);
    check("t2_stream", stream, 32'h000F_3CA5);
    check("t2_shifts", shift_cnt, 20);
    check("t2_done_cyc", dc, 29);
    $display("[TB] t2 stalled load: done_cyc=%0d stall_ok=%0d", dc, so);

    // 3: start pulses mid-SHIFT and in DONE are ignored
    do_load(-1, 0, -1, 1'b1, dc, so, ab);
    tick(4);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_shifts", shift_cnt, 20);
    check("t3_stream", stream, 32'h000F_3CA5);
    check("t3_idle_busy", {31'd0, busy}, 0);
    $display("[TB] t3 ignored starts: done_cnt=%0d shifts=%0d", done_cnt, shift_cnt);

    // 4: abort on shift 9, then a clean load
    do_load(-1, 0, 9, 1'b0, dc, so, ab);
    check("t4_aborted", {31'd0, ab}, 1);
    check("t4_abort_outs", {28'd0, busy, done, cfg_ready, ccff_shift_en}, 0);
    tick(3);
    check("t4_no_done", done_cnt, 0);
    check("t4_abort_shifts", shift_cnt, 10);
    do_load(-1, 0, -1, 1'b0, dc, so, ab);
    tick(2);
    check("t4_reload_stream", stream, 32'h000F_3CA5);
    check("t4_reload_done_cyc", dc, 24);
    $display("[TB] t4 abort+reload: done_cyc=%0d", dc);

    // 5: reset asserted during LOAD
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    check("t5_in_load", {30'd0, busy, cfg_ready}, 32'd3);
    prog_reset_n = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 8'hA5;
    tick(1);
    prog_reset_n = 1'b1;
    cfg_valid = 1'b0;
    check("t5_reset_outs", {26'd0, busy, done, err, cfg_ready, ccff_head, ccff_shift_en}, 32'd0);
    tick(1);
    check("t5_stays_idle", {31'd0, busy}, 0);
    do_load(-1, 0, -1, 1'b0, dc, so, ab);
    tick(2);
    check("t5_after_stream", stream, 32'h000F_3CA5);
    check("t5_after_done_cyc", dc, 24);
    $display("[TB] t5 reset in load: done_cyc=%0d", dc);

`ifdef CCFF_CHECK_EN
    // 6: readback check against the chain model
    prog_reset_n = 1'b0;
    tick(1);
    prog_reset_n = 1'b1;
    tick(1);
    do_load(-1, 0, -1, 1'b0, dc, so, ab);
    tick(1);
    check("t6_first_unchecked", {31'd0, err_at_done}, 0);
    do_load(-1, 0, -1, 1'b0, dc, so, ab);
    tick(1);
    check("t6_second_clean", {31'd0, err_at_done}, 0);
    chain[5] = ~chain[5];
    tick(1);
    do_load(-1, 0, -1, 1'b0, dc, so, ab);
    tick(2);
    check("t6_err_first_shift", err_first, 6);
    check("t6_err_at_done", {31'd0, err_at_done}, 1);
    check("t6_err_sticky", {31'd0, err}, 1);
    do_load(-1, 0, -1, 1'b0, dc, so, ab);
    tick(1);
    check("t6_err_cleared", {31'd0, err_at_done}, 0);
    $display("[TB] t6 readback: err_first=%0d", err_first);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
